// File: rtl/fir_out_requant.sv
// fir_out_requant
//   Requantises the wide signed Q28 accumulator of the upstream FIR filter
//   down to an OUT_W-bit Q16 sample. The sample is shifted right by SHIFT
//   with rounding and saturated. The result is buffered in a DEPTH-entry
//   show-ahead FIFO toward the writer/DAC stage. Saturation events are
//   counted for gain staging.
//
//   Build option: define FIR_RQ_CONVERGENT_EN to select round-half-to-even.
//   Otherwise the default is round-half-up.
//
// Ports
//   clk        clock, rising edge
//   reset      asynchronous, active-high, clears all state
//   in_data    signed filter sample (IN_W bits)
//   in_valid   in_data valid this cycle
//   in_ready   block can accept a sample (registers only)
//   out_data   signed requantised sample at FIFO head (OUT_W bits)
//   out_valid  FIFO non-empty
//   out_ready  consumer takes head this cycle
//   sat_clr    synchronous clear of sat_cnt / sat_flag
//   sat_cnt    saturation event count, sticks at 0xFFFF
//   sat_flag   sticky saturation indicator
module fir_out_requant #(
  parameter int IN_W  = 161,
  parameter int SHIFT = 12,
  parameter int OUT_W = 17,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  input  logic             sat_clr,
  output logic [15:0]      sat_cnt,
  output logic             sat_flag
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  localparam logic signed [IN_W:0] ONE   = 1;
  localparam logic signed [IN_W:0] HALF  = ONE <<< (SHIFT - 1);
  localparam logic signed [IN_W:0] MAX_V = {{(IN_W + 2 - OUT_W){1'b0}}, {(OUT_W - 1){1'b1}}};
  localparam logic signed [IN_W:0] MIN_V = {{(IN_W + 2 - OUT_W){1'b1}}, {(OUT_W - 1){1'b0}}};

  logic signed [IN_W:0] ext;
  logic signed [IN_W:0] rnd_add;
  logic signed [IN_W:0] rnd_sum;
  logic signed [IN_W:0] shifted;
  logic [OUT_W-1:0]     q_data;
  logic                 q_sat;

  logic                 s1_valid;
  logic [OUT_W-1:0]     s1_data;
  logic                 s1_sat;

  logic [OUT_W-1:0]     mem [DEPTH];
  logic [PW-1:0]        wr_ptr;
  logic [PW-1:0]        rd_ptr;
  logic [CW-1:0]        count;

  logic                 accept;
  logic                 push;
  logic                 pop;

  // One extra bit of headroom makes the rounding addition overflow-free.
  always_comb begin
    ext = $signed({in_data[IN_W-1], in_data});
`ifdef FIR_RQ_CONVERGENT_EN
    // Adding half-1 plus the LSB of the kept part carries only when the
    // discarded fraction is above half, or is exactly half with an odd
    // kept part. That yields the even result on ties.
    rnd_add = HALF - ONE + $signed({{IN_W{1'b0}}, ext[SHIFT]});
`else
    rnd_add = HALF;
`endif
    rnd_sum = ext + rnd_add;
    shifted = rnd_sum >>> SHIFT;
    if (shifted > MAX_V) begin
      q_data = {1'b0, {(OUT_W - 1){1'b1}}};
      q_sat  = 1'b1;
    end else if (shifted < MIN_V) begin
      q_data = {1'b1, {(OUT_W - 1){1'b0}}};
      q_sat  = 1'b1;
    end else begin
      q_data = shifted[OUT_W-1:0];
      q_sat  = 1'b0;
    end
  end

  // Counting the stage-1 slot as occupied guarantees the FIFO never overflows.
  assign in_ready  = (count + CW'(s1_valid)) < CW'(DEPTH);
  assign accept    = in_valid && in_ready;
  assign push      = s1_valid;
  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready;
  assign out_data  = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_sat   <= 1'b0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_data <= q_data;
        s1_sat  <= q_sat;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push) begin
        mem[wr_ptr] <= s1_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // A clear wins over a coincident saturation write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sat_cnt  <= '0;
      sat_flag <= 1'b0;
    end else if (sat_clr) begin
      sat_cnt  <= '0;
      sat_flag <= 1'b0;
    end else if (push && s1_sat) begin
      sat_flag <= 1'b1;
      if (sat_cnt != 16'hFFFF) begin
        sat_cnt <= sat_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_fir_out_requant.sv
// tb_fir_out_requant
//   Directed and randomized checks of fir_out_requant against a queue-based
//   reference model of the requantiser and its output buffer.
module tb_fir_out_requant;

  localparam int IN_W  = 161;
  localparam int SHIFT = 12;
  localparam int OUT_W = 17;
  localparam int DEPTH = 4;

  typedef struct {
    logic [OUT_W-1:0] d;
    logic             s;
  } ent_t;

  logic             clk = 1'b0;
  logic             reset;
  logic [IN_W-1:0]  in_data;
  logic             in_valid;
  logic             in_ready;
  logic [OUT_W-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             sat_clr;
  logic [15:0]      sat_cnt;
  logic             sat_flag;

  fir_out_requant #(.IN_W(IN_W), .SHIFT(SHIFT), .OUT_W(OUT_W), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sat_clr   (sat_clr),
    .sat_cnt   (sat_cnt),
    .sat_flag  (sat_flag)
  );

  always #5 clk = ~clk;

  int     n_cmp = 0;
  int     n_bad = 0;
  int     edge_n = 0;
  bit     chk_en = 1'b1;
  bit     last_acc;

  ent_t   fifo_q[$];
  bit     s1_v;
  ent_t   s1_e;
  int     m_cnt;
  bit     m_flag;
  integer got_q[$];
  int     pop_edge_q[$];

  task automatic chk(input string tag, input integer got, input integer exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [IN_W-1:0] sx(input longint v);
    return IN_W'(v);
  endfunction

  // Floor, then round by inspecting the discarded fraction, then clamp.
  function automatic ent_t ref_requant(input logic [IN_W-1:0] x);
    logic signed [IN_W+1:0] xe, q, r, half, hi, lo;
    bit conv;
    ent_t e;
`ifdef FIR_RQ_CONVERGENT_EN
    conv = 1'b1;
`else
    conv = 1'b0;
`endif
    xe   = $signed({{2{x[IN_W-1]}}, x});
    q    = xe >>> SHIFT;
    r    = xe - (q <<< SHIFT);
    half = 1;
    half = half <<< (SHIFT - 1);
    if (r > half) q = q + 1;
    else if (r == half && (!conv || q[0])) q = q + 1;
    hi = 1;
    hi = (hi <<< (OUT_W - 1)) - 1;
    lo = -hi - 1;
    if (q > hi) begin
      e.d = hi[OUT_W-1:0]; e.s = 1'b1;
    end else if (q < lo) begin
      e.d = lo[OUT_W-1:0]; e.s = 1'b1;
    end else begin
      e.d = q[OUT_W-1:0];  e.s = 1'b0;
    end
    return e;
  endfunction

  function automatic bit m_ready();
    return (fifo_q.size() + (s1_v ? 1 : 0)) < DEPTH;
  endfunction

  function automatic logic [IN_W-1:0] rand_in();
    logic [IN_W-1:0] v;
    v = '0;
    for (int i = 0; i < 6; i++) v = {v[IN_W-33:0], 32'($urandom)};
    case ($urandom_range(0, 3))
      0:       return sx(longint'($signed(v[27:0])));
      1:       return sx(longint'($signed(v[29:0])));
      2:       return sx(longint'($signed({v[20:0], 12'h800})));
      default: return v;
    endcase
  endfunction

  task automatic check_all();
    chk("in_ready", in_ready, m_ready());
    chk("out_valid", out_valid, fifo_q.size() != 0);
    if (fifo_q.size() != 0) chk("out_data", $signed(out_data), $signed(fifo_q[0].d));
    chk("sat_cnt", sat_cnt, m_cnt);
    chk("sat_flag", sat_flag, m_flag);
  endtask

  task automatic model_reset();
    fifo_q.delete();
    s1_v   = 1'b0;
    m_cnt  = 0;
    m_flag = 1'b0;
  endtask

  // One clock: decide accept/pop from the model, advance, then check.
  task automatic step();
    bit   acc, pop;
    ent_t e;
    acc = in_valid && m_ready();
    pop = (fifo_q.size() != 0) && out_ready;
    if (pop) got_q.push_back($signed(out_data));
    @(posedge clk);
    edge_n++;
    if (pop) begin
      e = fifo_q.pop_front();
      pop_edge_q.push_back(edge_n);
    end
    if (sat_clr) begin
      m_cnt = 0; m_flag = 1'b0;
    end else if (s1_v && s1_e.s) begin
      if (m_cnt != 65535) m_cnt++;
      m_flag = 1'b1;
    end
    if (s1_v) fifo_q.push_back(s1_e);
    s1_v = acc;
    if (acc) s1_e = ref_requant(in_data);
    last_acc = acc;
    #1;
    if (chk_en) check_all();
  endtask

  task automatic single(input string tag, input longint x, input integer exp);
    in_valid = 1'b1; in_data = sx(x); out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    chk({tag, "_valid"}, out_valid, 1);
    chk(tag, $signed(out_data), exp);
    step();
  endtask

  initial begin
    int idx;
    int acc_edge0;
    reset = 1'b1; in_data = '0; in_valid = 1'b0; out_ready = 1'b0; sat_clr = 1'b0;
    model_reset();
    #12;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_sat_cnt", sat_cnt, 0);
    chk("rst_sat_flag", sat_flag, 0);
    reset = 1'b0;

    // Rounding
    single("rnd_1800", 64'h1800, 2);
`ifdef FIR_RQ_CONVERGENT_EN
    single("rnd_2800", 64'h2800, 2);
`else
    single("rnd_2800", 64'h2800, 3);
`endif
    single("rnd_neg2800", -64'sh2800, -2);
    single("rnd_27ff", 64'h27FF, 2);

    // Saturation
    single("sat_pos", 64'sd1 <<< 40, 65535);
    single("sat_neg", -(64'sd1 <<< 40), -65536);
    single("sat_round", 64'h0FFFF800, 65535);
    chk("sat_cnt3", sat_cnt, 3);
    chk("sat_flag1", sat_flag, 1);
    sat_clr = 1'b1; step(); sat_clr = 1'b0;
    chk("clr_cnt", sat_cnt, 0);
    chk("clr_flag", sat_flag, 0);

    // Clear coinciding with a saturating write
    in_valid = 1'b1; in_data = sx(64'sd1 <<< 40);
    step();
    in_valid = 1'b0; sat_clr = 1'b1;
    step();
    sat_clr = 1'b0;
    chk("clr_wins_cnt", sat_cnt, 0);
    chk("clr_wins_flag", sat_flag, 0);
    step();

    // Backpressure
    out_ready = 1'b0; idx = 0;
    for (int c = 0; c < 8; c++) begin
      in_valid = (idx < 6); in_data = sx(longint'(idx + 1) * 4096);
      step();
      if (last_acc) idx++;
    end
    chk("bp_accepted", idx, 4);
    chk("bp_in_ready", in_ready, 0);
    got_q.delete(); out_ready = 1'b1;
    for (int c = 0; c < 30 && got_q.size() < 6; c++) begin
      in_valid = (idx < 6); in_data = sx(longint'(idx + 1) * 4096);
      step();
      if (last_acc) idx++;
    end
    in_valid = 1'b0;
    chk("bp_count", got_q.size(), 6);
    for (int i = 0; i < 6; i++) if (i < got_q.size()) chk("bp_order", got_q[i], i + 1);

    // Streaming ramp
    got_q.delete(); pop_edge_q.delete(); out_ready = 1'b1; acc_edge0 = 0;
    for (int k = 0; k < 100; k++) begin
      in_valid = 1'b1; in_data = sx(longint'(k - 50) * 4096);
      chk("stream_in_ready", in_ready, 1);
      step();
      if (k == 0) acc_edge0 = edge_n;
    end
    in_valid = 1'b0;
    repeat (4) step();
    chk("stream_count", got_q.size(), 100);
    for (int k = 0; k < 100; k++) begin
      if (k < got_q.size()) begin
        chk("stream_data", got_q[k], k - 50);
        chk("stream_edge", pop_edge_q[k], acc_edge0 + 2 + k);
      end
    end

    // Randomized traffic
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      sat_clr   = ($urandom_range(0, 31) == 0);
      in_data   = rand_in();
      step();
    end
    in_valid = 1'b0; sat_clr = 1'b0; out_ready = 1'b1;
    repeat (6) step();

    // Reset mid-operation with 3 buffered entries
    out_ready = 1'b0; in_valid = 1'b1; in_data = sx(64'sd1 <<< 40);
    repeat (3) step();
    in_valid = 1'b0;
    step();
    chk("pre_rst_valid", out_valid, 1);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_sat_cnt", sat_cnt, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    #1 reset = 1'b0;
    model_reset();
    in_valid = 1'b1; in_data = sx(64'h5000); out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    chk("post_rst_lat1", out_valid, 0);
    step();
    chk("post_rst_lat2", out_valid, 1);
    chk("post_rst_data", $signed(out_data), 5);
    step();

    // Counter saturation
    chk_en = 1'b0;
    in_valid = 1'b1; in_data = sx(64'sd1 <<< 40); out_ready = 1'b1;
    repeat (65537) step();
    in_valid = 1'b0;
    repeat (3) step();
    chk_en = 1'b1;
    chk("cnt_hold", sat_cnt, 16'hFFFF);
    chk("cnt_flag", sat_flag, 1);
    check_all();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
